// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl_if : request + latch-bank signal bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_d;
  logic [WIDTH-1:0] req_mask;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] rn;
  logic [WIDTH-1:0] setn;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_vld;

  modport master (
    output req_valid, req_op, req_d, req_mask,
    input  req_ready, d, e, rn, setn, done, err, shadow, shadow_vld
  );

  modport slave (
    input  req_valid, req_op, req_d, req_mask,
    output req_ready, d, e, rn, setn, done, err, shadow, shadow_vld
  );
endinterface
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl : timed load/set/clear sequencer for a latch bank
// Revision: 1.0
// ----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl #(
  parameter int WIDTH = 8,
  parameter int T_SU  = 1,
  parameter int T_PW  = 2,
  parameter int T_HD  = 1
) (
  input  logic clk,
  input  logic rst,
  gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [1:0] c_op_load  = 2'b00;
  localparam logic [1:0] c_op_set   = 2'b01;
  localparam logic [1:0] c_op_clear = 2'b10;
  localparam logic [1:0] c_op_rsvd  = 2'b11;
  localparam logic [3:0] c_su_load  = 4'(T_SU - 1);
  localparam logic [3:0] c_pw_load  = 4'(T_PW - 1);
  localparam logic [3:0] c_hd_load  = 4'(T_HD - 1);

  state_t           r_state, w_state_n;
  logic [3:0]       r_cnt, w_cnt_n;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask, r_d, r_e, r_rn, r_setn, r_shadow, r_vld;
  logic             r_done, r_err, w_done_n, w_ready, w_accept, w_rsvd, w_pulse_n;

  // DONE is registered, so READY is also held low while it is high to give the
  // one-cycle gap after every completion, including the reserved-op path.
  assign w_ready  = (r_state == IDLE) && !rst && !r_done;
  assign w_accept = bus.req_valid && w_ready;
  assign w_rsvd   = w_accept && (bus.req_op == c_op_rsvd);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_rsvd) begin
          w_state_n = SETUP;
          w_cnt_n   = c_su_load;
        end
      end
      SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_n = PULSE;
          w_cnt_n   = c_pw_load;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_n = HOLD;
          w_cnt_n   = c_hd_load;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_n = IDLE;
          w_cnt_n   = 4'd0;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
    endcase
    w_done_n  = ((w_state_n == HOLD) && (w_cnt_n == 4'd0)) || w_rsvd;
    w_pulse_n = (w_state_n == PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_op     <= c_op_load;
      r_mask   <= '0;
      r_d      <= '0;
      r_e      <= '0;
      r_rn     <= '1;
      r_setn   <= '1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_shadow <= '0;
      r_vld    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_done_n;
      r_err   <= w_rsvd;
      if (w_accept && !w_rsvd) begin
        r_op   <= bus.req_op;
        r_mask <= bus.req_mask;
        if (bus.req_op == c_op_load) r_d <= bus.req_d;
      end
      // Strobes are registered so the latch bank sees glitch-free pulses.
      r_e    <= (w_pulse_n && r_op == c_op_load)  ? r_mask  : '0;
      r_setn <= (w_pulse_n && r_op == c_op_set)   ? ~r_mask : '1;
      r_rn   <= (w_pulse_n && r_op == c_op_clear) ? ~r_mask : '1;
      if (r_done && !r_err) begin
        case (r_op)
          c_op_load:  r_shadow <= (r_shadow & ~r_mask) | (r_d & r_mask);
          c_op_set:   r_shadow <= r_shadow | r_mask;
          c_op_clear: r_shadow <= r_shadow & ~r_mask;
          default:    r_shadow <= r_shadow;
        endcase
        r_vld <= r_vld | r_mask;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.d          = r_d;
  assign bus.e          = r_e;
  assign bus.rn         = r_rn;
  assign bus.setn       = r_setn;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.shadow     = r_shadow;
  assign bus.shadow_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl : directed + random bench with cycle-timeline model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl;

  localparam int WIDTH = 8;
  localparam int T_SU  = 1;
  localparam int T_PW  = 2;
  localparam int T_HD  = 1;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  logic [7:0] m_sh;
  logic [7:0] m_vld;
  logic [7:0] m_d;

  gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl #(
    .WIDTH(WIDTH), .T_SU(T_SU), .T_PW(T_PW), .T_HD(T_HD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one request from acceptance to the first cycle after completion,
  // predicting each cycle from its position in the SETUP/PULSE/HOLD timeline.
  task automatic run_op(input logic [1:0] op, input logic [7:0] dv, input logic [7:0] mk,
                        input bit hold_next, input logic [1:0] nop,
                        input logic [7:0] nd, input logic [7:0] nmk);
    int         waited;
    int         lat;
    bit         in_pulse;
    logic [7:0] ee, er, es;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_d     = dv;
    bus.req_mask  = mk;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    if (hold_next) begin
      bus.req_op   = nop;
      bus.req_d    = nd;
      bus.req_mask = nmk;
    end else begin
      bus.req_valid = 1'b0;
    end
    lat = (op == 2'b11) ? 1 : T_SU + T_PW + T_HD;
    if (op == 2'b00) m_d = dv;
    for (int k = 1; k <= lat; k++) begin
      in_pulse = (op != 2'b11) && (k > T_SU) && (k <= T_SU + T_PW);
      ee = (in_pulse && op == 2'b00) ? mk : 8'h00;
      es = (in_pulse && op == 2'b01) ? ~mk : 8'hFF;
      er = (in_pulse && op == 2'b10) ? ~mk : 8'hFF;
      check("e", {24'd0, bus.e}, {24'd0, ee});
      check("setn", {24'd0, bus.setn}, {24'd0, es});
      check("rn", {24'd0, bus.rn}, {24'd0, er});
      check("d", {24'd0, bus.d}, {24'd0, m_d});
      check("done", {31'd0, bus.done}, {31'd0, (k == lat)});
      check("err", {31'd0, bus.err}, {31'd0, (op == 2'b11 && k == 1)});
      check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      check("exclusive", {24'd0, (bus.e & ~bus.rn) | (bus.e & ~bus.setn) | (~bus.rn & ~bus.setn)}, 32'd0);
      check("shadow_hold", {24'd0, bus.shadow}, {24'd0, m_sh});
      tick();
    end
    case (op)
      2'b00:   m_sh = (m_sh & ~mk) | (dv & mk);
      2'b01:   m_sh = m_sh | mk;
      2'b10:   m_sh = m_sh & ~mk;
      default: m_sh = m_sh;
    endcase
    if (op != 2'b11) m_vld = m_vld | mk;
    check("shadow", {24'd0, bus.shadow}, {24'd0, m_sh});
    check("shadow_vld", {24'd0, bus.shadow_vld}, {24'd0, m_vld});
    check("ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("done_after", {31'd0, bus.done}, 32'd0);
    check("err_after", {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    logic [1:0] rop;
    logic [7:0] rd, rm;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_d     = 8'h00;
    bus.req_mask  = 8'h00;
    m_sh = 8'h00; m_vld = 8'h00; m_d = 8'h00;
    repeat (3) tick();

    check("rst_d", {24'd0, bus.d}, 32'h00);
    check("rst_e", {24'd0, bus.e}, 32'h00);
    check("rst_rn", {24'd0, bus.rn}, 32'hFF);
    check("rst_setn", {24'd0, bus.setn}, 32'hFF);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_shadow", {24'd0, bus.shadow}, 32'h00);
    check("rst_vld", {24'd0, bus.shadow_vld}, 32'h00);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("ready_post_rst", {31'd0, bus.req_ready}, 32'd1);

    run_op(2'b00, 8'hA5, 8'hFF, 1'b0, 2'b00, 8'h00, 8'h00);
    check("load_shadow_a5", {24'd0, bus.shadow}, 32'hA5);
    run_op(2'b01, 8'h00, 8'h0F, 1'b0, 2'b00, 8'h00, 8'h00);
    check("set_shadow_af", {24'd0, bus.shadow}, 32'hAF);
    run_op(2'b10, 8'h00, 8'h81, 1'b0, 2'b00, 8'h00, 8'h00);
    check("clear_shadow_2e", {24'd0, bus.shadow}, 32'h2E);
    run_op(2'b11, 8'h5A, 8'hFF, 1'b0, 2'b00, 8'h00, 8'h00);
    check("rsvd_shadow_2e", {24'd0, bus.shadow}, 32'h2E);
    run_op(2'b01, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    run_op(2'b00, m_d, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);

    // Valid held through a busy op with a new load pending: only one acceptance.
    run_op(2'b01, 8'h00, 8'hF0, 1'b1, 2'b00, 8'h11, 8'hFF);
    run_op(2'b00, 8'h11, 8'hFF, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    check("no_second_accept", {31'd0, bus.req_ready}, 32'd1);
    check("no_second_d", {24'd0, bus.d}, 32'h11);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      rop = 2'($urandom_range(0, 3));
      rm  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rd  = (rm == 8'h00) ? m_d : 8'($urandom);
      run_op(rop, rd, rm, 1'b0, 2'b00, 8'h00, 8'h00);
    end

    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_d     = 8'hC3;
    bus.req_mask  = 8'hFF;
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("abort_d_c1", {24'd0, bus.d}, 32'hC3);
    rst = 1'b1;
    tick();
    check("abort_e", {24'd0, bus.e}, 32'h00);
    check("abort_rn", {24'd0, bus.rn}, 32'hFF);
    check("abort_setn", {24'd0, bus.setn}, 32'hFF);
    check("abort_vld", {24'd0, bus.shadow_vld}, 32'h00);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_ready_rst", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("abort_ready_c3", {31'd0, bus.req_ready}, 32'd1);
    check("abort_done_c3", {31'd0, bus.done}, 32'd0);
    check("abort_shadow_c3", {24'd0, bus.shadow}, 32'h00);
    m_sh = 8'h00; m_vld = 8'h00; m_d = 8'h00;
    run_op(2'b01, 8'h00, 8'h3C, 1'b0, 2'b00, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl.md
GF180MCU_FD_SC_MCU9T5V0__LATRSNQ_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__latrsnq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of latch bits driven.
REQ-002 Parameter T_SU, default 1: D-to-E setup phase length in CLK cycles, legal range 1..15.
REQ-003 Parameter T_PW, default 2: E/RN/SETN pulse length in CLK cycles, legal range 1..15.
REQ-004 Parameter T_HD, default 1: hold phase length in CLK cycles, legal range 1..15.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 REQ_VALID  input  1  request present.
REQ-008 REQ_READY  output  1  controller accepts a request this cycle.
REQ-009 REQ_OP  input  2  op code: 00 load, 01 set, 10 clear, 11 reserved.
REQ-010 REQ_D  input  WIDTH  load data.
REQ-011 REQ_MASK  input  WIDTH  per-bit select.
REQ-012 D  output  WIDTH  data to the latch bank.
REQ-013 E  output  WIDTH  per-bit latch enable, active-high.
REQ-014 RN  output  WIDTH  per-bit latch clear, active-low.
REQ-015 SETN  output  WIDTH  per-bit latch set, active-low.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 ERR  output  1  one-cycle pulse, coincident with DONE, for reserved op.
REQ-018 SHADOW  output  WIDTH  expected latch contents.
REQ-019 SHADOW_VLD  output  WIDTH  per-bit SHADOW validity.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, PULSE, HOLD; REQ_READY SHALL be 1 only in IDLE with RST low.
REQ-021 Handshake: request SHALL be accepted on a rising edge with REQ_VALID=1 and REQ_READY=1; REQ_OP, REQ_D and REQ_MASK SHALL be registered at acceptance and used for the whole operation.
REQ-022 Ops 00/01/10: IDLE->SETUP at acceptance; SETUP lasts T_SU cycles, PULSE lasts T_PW cycles, HOLD lasts T_HD cycles, then the FSM returns to IDLE; a single 4-bit down-counter times each phase.
REQ-023 D SHALL be updated to the registered REQ_D only on a load acceptance edge and held otherwise, including through set/clear ops.
REQ-024 PULSE, load: E = MASK; set: SETN = ~MASK; clear: RN = ~MASK; all other outputs inactive (E=0, RN=SETN=all ones).
REQ-025 Outside PULSE, E SHALL be 0 and RN and SETN all ones; on any bit, E, RN-low and SETN-low SHALL be mutually exclusive in every cycle.
REQ-026 DONE SHALL be 1 in the last HOLD cycle; REQ_READY SHALL rise the following cycle.
REQ-027 Latency from acceptance edge to DONE SHALL be T_SU+T_PW+T_HD cycles; back-to-back requests SHALL be separated by exactly one IDLE cycle.
REQ-028 On the edge ending DONE: load SHADOW=(SHADOW&~MASK)|(D&MASK); set SHADOW|=MASK; clear SHADOW&=~MASK; SHADOW_VLD|=MASK.
REQ-029 MASK=0: full phase sequence SHALL run with no output toggling, DONE SHALL pulse, and SHADOW/SHADOW_VLD SHALL be unchanged.
REQ-030 Op 11: accepted, no SETUP/PULSE/HOLD; DONE and ERR SHALL pulse in the cycle after acceptance; D, E, RN, SETN, SHADOW and SHADOW_VLD unchanged.
REQ-031 REQ_VALID held while REQ_READY=0 SHALL be ignored; no request is queued.

Reset
REQ-032 RST=1 at a rising edge SHALL force IDLE, counter 0, D=0, E=0, RN=all ones, SETN=all ones, DONE=0, ERR=0, SHADOW=0, SHADOW_VLD=0.
REQ-033 RST during any phase SHALL abort the operation at the next edge with no DONE and no SHADOW update; REQ_READY SHALL be 1 in the first cycle after RST deasserts.

Verification (WIDTH=8, T_SU=1, T_PW=2, T_HD=1, acceptance edge = cycle 0)
REQ-034 Load D=0xA5, MASK=0xFF from reset -> D=0xA5 from cycle 1; E=0xFF cycles 2-3; DONE=1 cycle 4; SHADOW=0xA5, SHADOW_VLD=0xFF, REQ_READY=1 cycle 5.
REQ-035 Then set MASK=0x0F -> SETN=0xF0 cycles 2-3, E=0, RN=0xFF, D stays 0xA5; SHADOW=0xAF after DONE.
REQ-036 Then clear MASK=0x81 -> RN=0x7E cycles 2-3; SHADOW=0x2E after DONE.
REQ-037 Op 11 -> DONE=1 and ERR=1 cycle 1, no E/RN/SETN activity, SHADOW unchanged; REQ_READY=1 cycle 2.
REQ-038 Load MASK=0xFF, RST=1 at cycle-2 edge -> cycle 2 onward E=0, RN=SETN=0xFF, SHADOW_VLD=0, no DONE; RST low at cycle 3 -> REQ_READY=1 cycle 3.
REQ-039 REQ_VALID held with new op during busy -> exactly one acceptance, at the first REQ_READY=1 edge.
